// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: MIPS opcode constants, FSM state
// encoding, default reset PC and the PC-field helper functions.
package instr_fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } fetch_state_e;

  // Word offset of a branch: sign-extended immediate scaled by 4.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Pseudo-direct jump target inside the current 256 MB region.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] idx);
    return {pc_plus4[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_logic.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
module next_pc_logic
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_idx,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target(pc_plus4, instr_idx);
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_offset(instr_idx[15:0]);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one word per instruction over a
// req/ready handshake and presents it for a single EXEC cycle.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired_cnt
);

  fetch_state_e state;
  logic [31:0]  next_pc;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign opcode    = instr[31:26];

  next_pc_logic u_next_pc (
    .pc_plus4  (pc_plus4),
    .instr_idx (instr[25:0]),
    .jump      (Jump),
    .branch    (Branch),
    .zero      (Zero),
    .next_pc   (next_pc)
  );

  // imem_req and instr_valid are registered alongside the state so that the
  // async reset drops an outstanding request in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= {RESET_PC[31:2], 2'b00};
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      retired_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            state       <= ST_EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        ST_EXEC: begin
          pc          <= next_pc;
          retired_cnt <= retired_cnt + 32'd1;
          instr_valid <= 1'b0;
          if (run) begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: three instances with different
// reset PCs share stimulus and are compared every cycle to a behavioural model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int N = 3;
  localparam logic [31:0] RPC [N] = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h8000_0000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        Jump = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;

  logic        dut_req   [N];
  logic [31:0] dut_addr  [N];
  logic [31:0] dut_instr [N];
  logic [5:0]  dut_op    [N];
  logic        dut_vld   [N];
  logic [31:0] dut_pc    [N];
  logic [31:0] dut_p4    [N];
  logic [31:0] dut_cnt   [N];

  int checks = 0;
  int failures = 0;
  int st_req = 0;
  int st_vld = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    instr_fetch_unit #(.RESET_PC(RPC[g])) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .imem_req    (dut_req[g]),
      .imem_addr   (dut_addr[g]),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .Jump        (Jump),
      .Branch      (Branch),
      .Zero        (Zero),
      .instr       (dut_instr[g]),
      .opcode      (dut_op[g]),
      .instr_valid (dut_vld[g]),
      .pc          (dut_pc[g]),
      .pc_plus4    (dut_p4[g]),
      .retired_cnt (dut_cnt[g])
    );
  end

  // ---------------- behavioural model ----------------
  // phase: 0 parked, 1 waiting for the memory word, 2 executing the held word
  int          m_phase = 0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_pc [N];

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                           input logic j, input logic b, input logic z);
    logic [31:0] p4;
    int off;
    p4 = cur + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      off = int'($signed(ins[15:0])) * 4;
      return p4 + 32'(off);
    end
    return p4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_instr = '0;
      m_cnt   = '0;
      for (int g = 0; g < N; g++) m_pc[g] = RPC[g];
    end else if (m_phase == 1) begin
      if (imem_ready) begin
        m_instr = imem_rdata;
        m_phase = 2;
      end
    end else if (m_phase == 2) begin
      for (int g = 0; g < N; g++) m_pc[g] = ref_next(m_pc[g], m_instr, Jump, Branch, Zero);
      m_cnt   = m_cnt + 32'd1;
      m_phase = run ? 1 : 0;
    end else if (run) begin
      m_phase = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      chk($sformatf("imem_req[%0d]", g), 32'(dut_req[g]), 32'(m_phase == 1));
      chk($sformatf("imem_addr[%0d]", g), dut_addr[g], m_pc[g]);
      chk($sformatf("pc[%0d]", g), dut_pc[g], m_pc[g]);
      chk($sformatf("pc_plus4[%0d]", g), dut_p4[g], m_pc[g] + 32'd4);
      chk($sformatf("instr[%0d]", g), dut_instr[g], m_instr);
      chk($sformatf("opcode[%0d]", g), 32'(dut_op[g]), 32'(m_instr[31:26]));
      chk($sformatf("instr_valid[%0d]", g), 32'(dut_vld[g]), 32'(m_phase == 2));
      chk($sformatf("retired_cnt[%0d]", g), dut_cnt[g], m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    Jump   = 1'($urandom);
    Branch = 1'($urandom);
    Zero   = 1'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    imem_ready = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  // Entered with the DUT requesting; returns one edge after the EXEC cycle.
  task automatic do_instr(input logic [31:0] word, input int waits, input logic j,
                          input logic b, input logic z, input logic run_fetch,
                          input logic run_exit);
    run = run_fetch;
    for (int w = 0; w < waits; w++) begin
      st_req += int'(dut_req[0]);
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      noise();
      cyc();
      st_vld += int'(dut_vld[0]);
    end
    st_req += int'(dut_req[0]);
    imem_ready = 1'b1;
    imem_rdata = word;
    noise();
    cyc();
    st_vld += int'(dut_vld[0]);
    imem_ready = 1'($urandom);
    imem_rdata = $urandom;
    Jump = j;
    Branch = b;
    Zero = z;
    run = run_exit;
    cyc();
    st_vld += int'(dut_vld[0]);
    noise();
    imem_ready = 1'b0;
  endtask

  initial begin
    logic [5:0]  ops [6];
    logic [31:0] beq_back;
    int          waits;
    logic        rf, rx;

    ops = '{OP_RTYPE, OP_BEQ, OP_LW, OP_SW, OP_ADDI, OP_J};
    beq_back = {OP_BEQ, 5'd1, 5'd2, 16'hFFFC};

    repeat (2) cyc();
    rst_n = 1'b1;
    for (int g = 0; g < N; g++) begin
      chk("reset pc", dut_pc[g], RPC[g]);
      chk("reset imem_req", 32'(dut_req[g]), 32'd0);
    end
    chk("reset instr", dut_instr[0], 32'd0);
    chk("reset instr_valid", 32'(dut_vld[0]), 32'd0);
    chk("reset retired_cnt", dut_cnt[0], 32'd0);

    // addi, zero-wait memory
    run = 1'b1;
    cyc();
    chk("first req", 32'(dut_req[0]), 32'd1);
    chk("first addr", dut_addr[0], 32'h0000_0000);
    chk("no early valid", 32'(dut_vld[0]), 32'd0);
    st_vld = 0;
    do_instr(32'h2008_0005, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("addi one valid", 32'(st_vld), 32'd1);
    chk("addi held instr", dut_instr[0], 32'h2008_0005);
    chk("addi opcode", 32'(dut_op[0]), 32'(OP_ADDI));
    chk("addi next addr", dut_addr[0], 32'h0000_0004);
    chk("addi retired", dut_cnt[0], 32'd1);
    chk("wrap next addr", dut_addr[1], 32'h0000_0000);
    chk("hi next addr", dut_addr[2], 32'h8000_0004);

    // jump beats taken branch
    do_reset();
    run = 1'b1;
    cyc();
    do_instr({OP_J, 26'h000_0040}, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("jump hi region", dut_addr[2], 32'h8000_0100);
    chk("jump lo region", dut_addr[0], 32'h0000_0100);
    chk("jump after wrap", dut_addr[1], 32'h0000_0100);

    // beq taken / not taken at pc 0x10
    do_instr({OP_J, 26'h000_0004}, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("jump to 0x10", dut_addr[0], 32'h0000_0010);
    do_instr(beq_back, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("beq taken", dut_addr[0], 32'h0000_0004);
    do_instr({OP_J, 26'h000_0004}, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    do_instr(beq_back, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("beq not taken", dut_addr[0], 32'h0000_0014);

    // three wait states
    st_req = 0;
    st_vld = 0;
    do_instr(32'h2008_0005, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("wait req cycles", 32'(st_req), 32'd4);
    chk("wait one valid", 32'(st_vld), 32'd1);
    chk("wait next addr", dut_addr[0], 32'h0000_0018);

    // run dropped during fetch
    st_vld = 0;
    do_instr(32'h2008_0005, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stop one valid", 32'(st_vld), 32'd1);
    chk("stop idle req", 32'(dut_req[0]), 32'd0);
    imem_ready = 1'b1;
    cyc();
    chk("stop still idle", 32'(dut_req[0]), 32'd0);
    chk("stop pc held", dut_pc[0], 32'h0000_001C);
    chk("stop retired", dut_cnt[0], 32'd7);

    // reset while a fetch is waiting
    imem_ready = 1'b0;
    run = 1'b1;
    cyc();
    cyc();
    chk("pre-reset req", 32'(dut_req[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("reset drops req", 32'(dut_req[0]), 32'd0);
    for (int g = 0; g < N; g++) chk("reset mid pc", dut_pc[g], RPC[g]);
    chk("reset mid cnt", dut_cnt[0], 32'd0);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    run = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("late ready instr", dut_instr[0], 32'd0);
    chk("late ready valid", 32'(dut_vld[0]), 32'd0);
    imem_ready = 1'b0;

    // randomized traffic
    run = 1'b1;
    cyc();
    for (int i = 0; i < 400; i++) begin
      waits = $urandom_range(0, 3);
      rf = ($urandom_range(0, 9) != 0);
      rx = ($urandom_range(0, 7) != 0);
      do_instr({ops[$urandom_range(0, 5)], 26'($urandom)}, waits,
               ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), rf, rx);
      if (!rx) begin
        repeat ($urandom_range(0, 2)) begin
          noise();
          imem_ready = 1'($urandom);
          imem_rdata = $urandom;
          cyc();
        end
        run = 1'b1;
        imem_ready = 1'($urandom);
        noise();
        cyc();
      end
    end
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
